// File: rtl/mem_sys_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_sys_pkg
// Description : Shared types and address constants for the instruction
//               memory loader / fetch block.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_sys_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        FETCH = 2'd3
    } state_t;

    localparam logic [31:0] c_BASE_ADDR = 32'h0040_0000;
    localparam int          c_ADDR_STEP = 4;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_counter.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_counter
// Description : Fetch program counter with load-to-base, increment, hold and
//               wrap after the last memory word.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_counter
    import mem_sys_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = c_BASE_ADDR,
    parameter int                    ADDR_STEP    = c_ADDR_STEP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load_base,
    input  logic                  i_advance,
    output logic [DATA_WIDTH-1:0] o_pc
);

    localparam logic [DATA_WIDTH-1:0] c_STEP      = DATA_WIDTH'(ADDR_STEP);
    localparam logic [DATA_WIDTH-1:0] c_LAST_ADDR =
        BASE_ADDR + DATA_WIDTH'((MEMORY_DEPTH - 1) * ADDR_STEP);

    logic [DATA_WIDTH-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (!rst_n || i_load_base) begin
            r_pc <= BASE_ADDR;
        end else if (i_advance) begin
            r_pc <= (r_pc == c_LAST_ADDR) ? BASE_ADDR : r_pc + c_STEP;
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/instr_mem_loader_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loader_fetch
// Description : Loads a program image into instruction memory over a
//               valid/ready stream, then sequences instruction fetches.
//               Define LOAD_CHECKSUM_EN to build the XOR load checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loader_fetch
    import mem_sys_pkg::*;
#(
    parameter int                    MEMORY_DEPTH = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = c_BASE_ADDR,
    parameter int                    ADDR_STEP    = c_ADDR_STEP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start_i,
    input  logic                  load_valid_i,
    input  logic                  load_last_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    output logic                  load_ready_o,
    output logic                  load_done_o,
    input  logic                  fetch_en_i,
    input  logic                  stall_i,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] load_csum_o
);

    localparam int c_IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

    state_t                r_state;
    logic [c_IDX_W-1:0]    r_idx;
    logic                  r_load_ready;
    logic                  r_load_done;
    logic [DATA_WIDTH-1:0] r_instr;
    logic                  r_instr_valid;
    logic [DATA_WIDTH-1:0] r_pc_out;
    logic [DATA_WIDTH-1:0] w_pc;
    logic [DATA_WIDTH-1:0] w_load_addr;
    logic                  w_load_hs;
    logic                  w_last_word;
    logic                  w_fetch_step;

    // A load restart pre-empts any handshake presented in the same cycle.
    assign w_load_hs    = r_load_ready & load_valid_i & ~load_start_i;
    assign w_last_word  = load_last_i | (r_idx == c_IDX_W'(MEMORY_DEPTH - 1));
    assign w_fetch_step = (r_state == FETCH) & fetch_en_i & ~stall_i & ~load_start_i;
    assign w_load_addr  = BASE_ADDR + DATA_WIDTH'(r_idx) * DATA_WIDTH'(ADDR_STEP);

    fetch_pc_counter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .MEMORY_DEPTH(MEMORY_DEPTH),
        .BASE_ADDR   (BASE_ADDR),
        .ADDR_STEP   (ADDR_STEP)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load_base(load_start_i | (r_state != FETCH)),
        .i_advance  (w_fetch_step),
        .o_pc       (w_pc)
    );

    always_comb begin
        mem_addr_o  = BASE_ADDR;
        mem_wdata_o = '0;
        case (r_state)
            LOAD: begin
                mem_addr_o  = w_load_addr;
                mem_wdata_o = load_data_i;
            end
            FETCH:   mem_addr_o = w_pc;
            default: ;
        endcase
    end

    assign mem_we_o = w_load_hs & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_load_ready  <= 1'b0;
            r_load_done   <= 1'b0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_pc_out      <= BASE_ADDR;
        end else if (load_start_i) begin
            r_state       <= LOAD;
            r_idx         <= '0;
            r_load_ready  <= 1'b1;
            r_load_done   <= 1'b0;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: ;
                LOAD: begin
                    if (w_load_hs) begin
                        r_idx <= r_idx + 1'b1;
                        if (w_last_word) begin
                            r_state      <= READY;
                            r_load_ready <= 1'b0;
                            r_load_done  <= 1'b1;
                        end
                    end
                end
                READY: begin
                    if (fetch_en_i) r_state <= FETCH;
                end
                FETCH: begin
                    if (!stall_i) begin
                        if (fetch_en_i) begin
                            r_instr       <= mem_rdata_i;
                            r_pc_out      <= w_pc;
                            r_instr_valid <= 1'b1;
                        end else begin
                            r_instr_valid <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

`ifdef LOAD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_csum;

    always_ff @(posedge clk) begin
        if (!rst_n || load_start_i) begin
            r_csum <= '0;
        end else if (w_load_hs) begin
            r_csum <= r_csum ^ load_data_i;
        end
    end

    assign load_csum_o = r_csum;
`else
    assign load_csum_o = '0;
`endif

    assign load_ready_o  = r_load_ready;
    assign load_done_o   = r_load_done;
    assign instr_o       = r_instr;
    assign instr_valid_o = r_instr_valid;
    assign pc_o          = r_pc_out;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem_loader_fetch
// Description : Directed plus randomized bench for instr_mem_loader_fetch
//               against a cycle-level reference model and a memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader_fetch;

    localparam logic [31:0] c_BASE = 32'h0040_0000;
    localparam logic [31:0] c_LAST = 32'h0040_007C;

    logic        clk;
    logic        rst_n;
    logic        load_start_i;
    logic        load_valid_i;
    logic        load_last_i;
    logic [31:0] load_data_i;
    logic        load_ready_o;
    logic        load_done_o;
    logic        fetch_en_i;
    logic        stall_i;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic [31:0] pc_o;
    logic [31:0] load_csum_o;

    instr_mem_loader_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start_i (load_start_i),
        .load_valid_i (load_valid_i),
        .load_last_i  (load_last_i),
        .load_data_i  (load_data_i),
        .load_ready_o (load_ready_o),
        .load_done_o  (load_done_o),
        .fetch_en_i   (fetch_en_i),
        .stall_i      (stall_i),
        .mem_we_o     (mem_we_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_addr_o   (mem_addr_o),
        .mem_rdata_i  (mem_rdata_i),
        .instr_o      (instr_o),
        .instr_valid_o(instr_valid_o),
        .pc_o         (pc_o),
        .load_csum_o  (load_csum_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: written by the DUT, combinational read.
    logic [31:0] tb_mem [0:31];
    logic [31:0] w_off;
    always_comb begin
        w_off = mem_addr_o - c_BASE;
        if (w_off < 32'd128) mem_rdata_i = tb_mem[w_off[6:2]];
        else                 mem_rdata_i = 32'hDEAD_BEEF;
    end
    always @(posedge clk) begin
        if (mem_we_o && (mem_addr_o - c_BASE) < 32'd128)
            tb_mem[w_off[6:2]] <= mem_wdata_o;
    end

    // Reference model (mode: 0 idle, 1 loading, 2 loaded, 3 fetching)
    int          m_mode;
    int          m_idx;
    logic [31:0] m_pc, m_instr, m_pcout, m_csum;
    logic        m_valid, m_done;
    logic [31:0] ref_mem [0:31];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_pc = c_BASE; m_instr = '0; m_pcout = c_BASE;
        m_csum = '0; m_valid = 1'b0; m_done = 1'b0;
    endtask

    task automatic cyc(input logic rn, input logic st, input logic v, input logic l,
                       input logic [31:0] d, input logic en, input logic sl);
        logic [31:0] e_addr;
        @(negedge clk);
        rst_n = rn; load_start_i = st; load_valid_i = v; load_last_i = l;
        load_data_i = d; fetch_en_i = en; stall_i = sl;
        #1;
        e_addr = (m_mode == 1) ? c_BASE + 32'(m_idx * 4) : (m_mode == 3) ? m_pc : c_BASE;
        chk("load_ready", {31'd0, load_ready_o}, {31'd0, m_mode == 1});
        chk("mem_we", {31'd0, mem_we_o}, {31'd0, rn && !st && v && m_mode == 1});
        chk("mem_addr", mem_addr_o, e_addr);
        chk("mem_wdata", mem_wdata_o, (m_mode == 1) ? d : 32'd0);
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else if (st) begin
            m_mode = 1; m_idx = 0; m_pc = c_BASE; m_valid = 1'b0; m_done = 1'b0; m_csum = '0;
        end else begin
            case (m_mode)
                1: if (v) begin
                    ref_mem[m_idx] = d;
`ifdef LOAD_CHECKSUM_EN
                    m_csum = m_csum ^ d;
`endif
                    if (l || m_idx == 31) begin m_mode = 2; m_done = 1'b1; end
                    m_idx++;
                end
                2: begin m_pc = c_BASE; if (en) m_mode = 3; end
                3: if (!sl) begin
                    if (en) begin
                        m_instr = ref_mem[(m_pc - c_BASE) >> 2];
                        m_pcout = m_pc;
                        m_valid = 1'b1;
                        m_pc    = (m_pc == c_LAST) ? c_BASE : m_pc + 32'd4;
                    end else begin
                        m_valid = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        #1;
        chk("load_done", {31'd0, load_done_o}, {31'd0, m_done});
        chk("instr_valid", {31'd0, instr_valid_o}, {31'd0, m_valid});
        chk("instr", instr_o, m_instr);
        chk("pc_o", pc_o, m_pcout);
        chk("load_csum", load_csum_o, m_csum);
    endtask

    initial begin
        logic [31:0] csum_exp;
        rst_n = 1'b0; load_start_i = 1'b0; load_valid_i = 1'b0; load_last_i = 1'b0;
        load_data_i = '0; fetch_en_i = 1'b0; stall_i = 1'b0;
        for (int i = 0; i < 32; i++) begin tb_mem[i] = '0; ref_mem[i] = '0; end
        model_reset();

        // Reset with busy inputs: no write may escape
        cyc(0, 1, 1, 1, $urandom, 1, 0);
        cyc(0, 0, 1, 0, $urandom, 1, 0);
        cyc(1, 0, 0, 0, $urandom, 1, 0);   // fetch_en ignored in IDLE

        // Three-word load
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 32'h11, 0, 0);
        cyc(1, 0, 1, 0, 32'h22, 0, 0);
        cyc(1, 0, 1, 1, 32'h33, 0, 0);
        cyc(1, 0, 1, 0, 32'h44, 0, 0);
        chk("tb_mem[2]", tb_mem[2], 32'h33);

        // Gapped load
        cyc(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            cyc(1, 0, (i % 2) == 0, i == 8, $urandom, 0, 0);

        // Full-depth load without last; the 33rd word is refused
        cyc(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 33; i++) cyc(1, 0, 1, 0, $urandom, 0, 0);

        // Fetch across the wrap, then stall
        for (int i = 0; i < 34; i++) cyc(1, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, $urandom_range(0, 1), 1);
        cyc(1, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 0);
        // Restart during fetch, with a colliding handshake request
        cyc(1, 1, 1, 0, $urandom, 1, 0);
        cyc(1, 0, 1, 0, $urandom, 0, 0);
        cyc(1, 0, 1, 1, $urandom, 0, 0);

        // Checksum load
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 32'hF0F0_F0F0, 0, 0);
        cyc(1, 0, 1, 0, 32'h0F0F_0F0F, 0, 0);
        cyc(1, 0, 1, 1, 32'h0000_00FF, 0, 0);
        cyc(1, 0, 1, 0, 32'h1234_5678, 0, 0);
`ifdef LOAD_CHECKSUM_EN
        csum_exp = 32'hFFFF_FF00;
`else
        csum_exp = 32'h0;
`endif
        chk("csum_directed", load_csum_o, csum_exp);

        // Reset in the middle of a load
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, $urandom, 0, 0);
        cyc(0, 0, 1, 0, $urandom, 0, 0);
        cyc(1, 0, 1, 0, $urandom, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 99) >= 2, $urandom_range(0, 99) < 3,
                $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 10,
                $urandom, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
